// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - op encoding and slice-width helper shared by the pipelined adder
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SW-bit ripple slice built from fulladder cells
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] A,
  input  logic [SW-1:0] B,
  input  logic          Cin,
  output logic [SW-1:0] S,
  output logic          Cout
);

  logic [SW:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    fulladder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .sum  (S[i]),
      .cout (c[i+1])
    );
  end

  assign Cout = c[SW];

endmodule

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined add/sub, one slice per stage; Zero/Ovf outputs under PIPELINED_ADDER_FLAGS_EN
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  op_t              Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef PIPELINED_ADDER_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Ovf
`endif
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  res_nx [STAGES];
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  slice_sum;
  logic [STAGES-1:0] slice_ci;
  logic [STAGES-1:0] slice_co;
  logic              unused_tail;

  // The whole pipe moves as one; it only freezes when the output is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + 1, so Cin is replaced by a forced 1.
  assign b_eff = (Op == OP_SUB) ? ~B : B;
  assign cin0  = (Op == OP_SUB) ? 1'b1 : Cin;

  // Slice 0 reads the ports; slice k reads operand bits and carry registered by stage k-1.
  always_comb begin
    op_a         = '0;
    op_b         = '0;
    slice_ci     = '0;
    op_a[SW-1:0] = A[SW-1:0];
    op_b[SW-1:0] = b_eff[SW-1:0];
    slice_ci[0]  = cin0;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k*SW +: SW] = a_q[k-1][k*SW +: SW];
      op_b[k*SW +: SW] = b_q[k-1][k*SW +: SW];
      slice_ci[k]      = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(
      .SW (SW)
    ) u_slice (
      .A    (op_a[k*SW +: SW]),
      .B    (op_b[k*SW +: SW]),
      .Cin  (slice_ci[k]),
      .S    (slice_sum[k*SW +: SW]),
      .Cout (slice_co[k])
    );
  end

  // Each stage's result word is the lower bits already resolved plus this stage's new slice.
  always_comb begin
    res_nx[0]         = '0;
    res_nx[0][SW-1:0] = slice_sum[SW-1:0];
    for (int k = 1; k < STAGES; k++) begin
      res_nx[k]              = res_q[k-1];
      res_nx[k][k*SW +: SW]  = slice_sum[k*SW +: SW];
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, bubbles shift like data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      carry_q[0] <= slice_co[0];
      res_q[0]   <= res_nx[0];
      a_q[0]     <= A;
      b_q[0]     <= b_eff;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        carry_q[k] <= slice_co[k];
        res_q[k]   <= res_nx[k];
        a_q[k]     <= a_q[k-1];
        b_q[k]     <= b_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign S         = res_q[STAGES-1];
  assign Cout      = carry_q[STAGES-1];

  // Operands in the last stage have no further consumer.
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic zero_nx;
  logic ovf_nx;
  logic zero_q;
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign zero_nx = (res_nx[STAGES-1] == '0);
  assign ovf_nx  = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ res_nx[STAGES-1][WIDTH-1] ^ slice_co[STAGES-1];

  // Flags are captured with the last stage so they track S and hold during stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= zero_nx;
      ovf_q  <= ovf_nx;
    end
  end

  assign Zero = zero_q;
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed bench for pipelined_adder (32x4 and 8x1 builds; flags under PIPELINED_ADDER_FLAGS_EN)
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    op_t         op;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic        out_ready;
  logic        cfg;
  logic [31:0] a;
  logic [31:0] b;
  op_t         op;
  logic [31:0] exp_s;
  logic        exp_c;
  logic        exp_v;

  logic        in_valid0, in_valid1;
  logic        rdy0, rdy1, ov0, ov1, co0, co1;
  logic [31:0] s0;
  logic [7:0]  s1;
  logic        cur_in_ready, cur_out_valid, cur_cout;
  logic [31:0] cur_s;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int pop_count = 0;
  int first_pop = -1;
  int last_pop  = 0;

  exp_t sb[$];
  vec_t vec32[8];
  vec_t vec8[8];

  always #5 clk = ~clk;

  assign in_valid0 = in_valid & ~cfg;
  assign in_valid1 = in_valid & cfg;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic z0, f0, z1, f1, cur_zero, cur_ovf;
  assign cur_zero = cfg ? z1 : z0;
  assign cur_ovf  = cfg ? f1 : f0;
`endif

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (rdy0),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Op        (op),
    .out_valid (ov0),
    .out_ready (out_ready),
    .S         (s0),
    .Cout      (co0)
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    .Zero      (z0),
    .Ovf       (f0)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (rdy1),
    .A         (a[7:0]),
    .B         (b[7:0]),
    .Cin       (cin),
    .Op        (op),
    .out_valid (ov1),
    .out_ready (out_ready),
    .S         (s1),
    .Cout      (co1)
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    .Zero      (z1),
    .Ovf       (f1)
`endif
  );

  assign cur_in_ready  = cfg ? rdy1 : rdy0;
  assign cur_out_valid = cfg ? ov1 : ov0;
  assign cur_s         = cfg ? {24'h0, s1} : s0;
  assign cur_cout      = cfg ? co1 : co0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cfg=%0d t=%0t)", tag, got, want, cfg, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a_, input logic [31:0] b_, input logic c_,
                              input op_t o_, input logic [31:0] s_, input logic co_, input logic v_);
    vec_t r;
    r.a = a_; r.b = b_; r.cin = c_; r.op = o_; r.s = s_; r.c = co_; r.v = v_;
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                 input op_t o, input int w);
    exp_t e;
    logic [32:0] r;
    logic [31:0] m, yy;
    logic cc;
    m    = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    yy   = ((o == OP_SUB) ? ~y : y) & m;
    cc   = (o == OP_SUB) ? 1'b1 : ci;
    r    = {1'b0, x & m} + {1'b0, yy} + {32'h0, cc};
    e.s  = r[31:0] & m;
    e.c  = (w == 32) ? r[32] : r[8];
    e.v  = (x[w-1] == yy[w-1]) && (e.s[w-1] != x[w-1]);
    return e;
  endfunction

  function automatic vec_t tv(input int i);
    return cfg ? vec8[i] : vec32[i];
  endfunction

  // Clock counter used to confirm back-to-back output cycles.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: record accepted operands, compare every consumed result in order.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1 && in_valid && cur_in_ready === 1'b1)
      sb.push_back('{s: exp_s, c: exp_c, v: exp_v});
    if (cur_out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", cur_out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("out_s", cur_s, e.s);
        check_eq("out_cout", cur_cout, e.c);
`ifdef PIPELINED_ADDER_FLAGS_EN
        check_eq("out_zero", cur_zero, (e.s == 32'h0));
        check_eq("out_ovf", cur_ovf, e.v);
`endif
        pop_count++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; op = v.op;
    exp_s = v.s; exp_c = v.c; exp_v = v.v;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    for (int n = 0; n < 50 && cur_in_ready !== 1'b1; n++) step();
    check_eq("send_ready", cur_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) step();
    check_eq("drain_empty", sb.size(), 0);
  endtask

  task automatic run_suite(input int st);
    vec_t lat;
    vec_t hold;
    exp_t e;
    int   w;
    logic [31:0] m, ra, rb;
    logic rc;
    op_t  ro;
    w = cfg ? 8 : 32;
    m = cfg ? 32'h0000_00FF : 32'hFFFF_FFFF;
    lat = cfg ? mk(32'hFF, 32'h01, 1'b0, OP_ADD, 32'h00, 1'b1, 1'b0)
              : mk(32'hFF, 32'h01, 1'b0, OP_ADD, 32'h100, 1'b0, 1'b0);

    // reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    step(); step();
    check_eq("rst_out_valid", cur_out_valid, 1'b0);
    check_eq("rst_s", cur_s, 32'h0);
    check_eq("rst_cout", cur_cout, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", cur_in_ready, 1'b1);
    out_ready = 1'b1;

    // latency of the first operation
    drive(lat);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < st; i++) begin
      check_eq("lat_early", cur_out_valid, 1'b0);
      step();
    end
    check_eq("lat_valid", cur_out_valid, 1'b1);
    check_eq("lat_s", cur_s, lat.s);
    check_eq("lat_cout", cur_cout, lat.c);
    drain();

    // directed vectors, back to back
    for (int i = 0; i < 8; i++) send(tv(i));
    drain();

    // throughput: 16 random ops on consecutive cycles
    pop_count = 0;
    first_pop = -1;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom() & m;
      rb = $urandom() & m;
      rc = 1'($urandom_range(0, 1));
      ro = op_t'(1'($urandom_range(0, 1)));
      e  = model(ra, rb, rc, ro, w);
      drive(mk(ra, rb, rc, ro, e.s, e.c, e.v));
      check_eq("tp_in_ready", cur_in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    drain();
    check_eq("tp_count", pop_count, 16);
    check_eq("tp_back_to_back", last_pop - first_pop, 15);

    // backpressure: hold a valid result for 5 cycles with a new op waiting
    hold = tv(4);
    send(hold);
    for (int n = 0; n < 20 && cur_out_valid !== 1'b1; n++) step();
    out_ready = 1'b0;
    pop_count = 0;
    drive(tv(5));
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_in_ready", cur_in_ready, 1'b0);
      step();
      check_eq("bp_valid", cur_out_valid, 1'b1);
      check_eq("bp_s", cur_s, hold.s);
      check_eq("bp_cout", cur_cout, hold.c);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", cur_in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    drain();
    check_eq("bp_count", pop_count, 2);

    // reset with operations in flight
    send(tv(0));
    send(tv(1));
    send(tv(2));
    rst_n = 1'b0;
    step();
    sb.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("mr_no_out", cur_out_valid, 1'b0);
      step();
    end
    pop_count = 0;
    send(tv(3));
    drain();
    check_eq("mr_new_count", pop_count, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;

    vec32[0] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0);
    vec32[1] = mk(32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);
    vec32[2] = mk(32'h0000_0007, 32'h0000_0005, 1'b1, OP_SUB, 32'h0000_0002, 1'b1, 1'b0);
    vec32[3] = mk(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
    vec32[4] = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, OP_ADD, 32'hACF1_3569, 1'b0, 1'b0);
    vec32[5] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
    vec32[6] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, OP_SUB, 32'h0000_0000, 1'b1, 1'b0);
    vec32[7] = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0);

    vec8[0]  = mk(32'hFF, 32'h00, 1'b1, OP_ADD, 32'h00, 1'b1, 1'b0);
    vec8[1]  = mk(32'h05, 32'h07, 1'b0, OP_SUB, 32'hFE, 1'b0, 1'b0);
    vec8[2]  = mk(32'h07, 32'h05, 1'b1, OP_SUB, 32'h02, 1'b1, 1'b0);
    vec8[3]  = mk(32'h80, 32'h01, 1'b0, OP_SUB, 32'h7F, 1'b1, 1'b1);
    vec8[4]  = mk(32'h78, 32'hF0, 1'b1, OP_ADD, 32'h69, 1'b1, 1'b0);
    vec8[5]  = mk(32'h7F, 32'h01, 1'b0, OP_ADD, 32'h80, 1'b0, 1'b1);
    vec8[6]  = mk(32'h00, 32'h00, 1'b0, OP_SUB, 32'h00, 1'b1, 1'b0);
    vec8[7]  = mk(32'h0F, 32'h01, 1'b0, OP_ADD, 32'h10, 1'b0, 1'b0);

    cfg = 1'b0;
    run_suite(4);
    cfg = 1'b1;
    run_suite(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
